// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the round-robin adder arbiter.
package adder_arb_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

endpackage

// File: rtl/adder_arbiter_rr_pick.sv
// Round-robin priority picker; when locked only the owner can be granted.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            lock_en_i,
    input  logic [IDW-1:0]  lock_owner_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_idx_o,
    output logic            any_o
);

    logic [IDW-1:0] sel;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        sel       = '0;
        if (lock_en_i) begin
            if (req_i[lock_owner_i]) begin
                gnt_o[lock_owner_i] = 1'b1;
                gnt_idx_o           = lock_owner_i;
                any_o               = 1'b1;
            end
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                sel = IDW'((32'(ptr_i) + i) % NREQ);
                if (!any_o && req_i[sel]) begin
                    gnt_o[sel] = 1'b1;
                    gnt_idx_o  = sel;
                    any_o      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/select_adder.sv
// 16-bit carry-select adder: the upper byte is precomputed for both carries.
module select_adder
    import adder_arb_pkg::*;
(
    input  word_t a_i,
    input  word_t b_i,
    input  logic  cin_i,
    output word_t sum_o,
    output logic  cout_o
);

    logic [8:0] lo;
    logic [8:0] hi0;
    logic [8:0] hi1;

    assign lo  = {1'b0, a_i[7:0]} + {1'b0, b_i[7:0]} + {8'd0, cin_i};
    assign hi0 = {1'b0, a_i[15:8]} + {1'b0, b_i[15:8]};
    assign hi1 = hi0 + 9'd1;

    assign sum_o[7:0]             = lo[7:0];
    assign {cout_o, sum_o[15:8]}  = lo[8] ? hi1 : hi0;

endmodule

// File: rtl/adder_arbiter.sv
// Shares one 16-bit adder among NREQ requesters; chained words hold the grant
// and feed carry-out into the next word's carry-in.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*WORD_W-1:0] req_a,
    input  logic [NREQ*WORD_W-1:0] req_b,
    input  logic [NREQ-1:0]        req_cin,
    input  logic [NREQ-1:0]        req_chain,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [WORD_W-1:0]      rsp_sum,
    output logic                   rsp_cout
);

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic           chain_c_q, chain_c_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    word_t          rsp_sum_q, rsp_sum_d;
    logic           rsp_cout_q, rsp_cout_d;

    logic            slot_free;
    logic [NREQ-1:0] pick_req;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            any_gnt;
    logic            cin_used;
    word_t           add_sum;
    logic            add_cout;
    logic [IDW-1:0]  next_ptr;

    // Masking requests (not grants) keeps req_ready low during reset and backpressure.
    assign slot_free = !rsp_valid_q || rsp_ready;
    assign pick_req  = (slot_free && !Reset) ? req_valid : '0;
    assign req_ready = gnt;
    assign cin_used  = (state_q == LOCKED) ? chain_c_q : req_cin[gnt_idx];
    assign next_ptr  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i        (pick_req),
        .ptr_i        (rr_ptr_q),
        .lock_en_i    (state_q == LOCKED),
        .lock_owner_i (owner_q),
        .gnt_o        (gnt),
        .gnt_idx_o    (gnt_idx),
        .any_o        (any_gnt)
    );

    select_adder u_add (
        .a_i    (req_a[gnt_idx*WORD_W +: WORD_W]),
        .b_i    (req_b[gnt_idx*WORD_W +: WORD_W]),
        .cin_i  (cin_used),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        chain_c_d   = chain_c_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        if (any_gnt) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = gnt_idx;
            rsp_sum_d   = add_sum;
            rsp_cout_d  = add_cout;
            chain_c_d   = add_cout;
            if (req_chain[gnt_idx]) begin
                state_d = LOCKED;
                owner_d = gnt_idx;
            end else begin
                state_d  = IDLE;
                rr_ptr_d = next_ptr;
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            chain_c_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            chain_c_q   <= chain_c_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: vector table plus chain/backpressure/reset sequences.
module tb_adder_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                Clk;
    logic                Reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*16-1:0]  req_a;
    logic [NREQ*16-1:0]  req_b;
    logic [NREQ-1:0]     req_cin;
    logic [NREQ-1:0]     req_chain;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [15:0]         rsp_sum;
    logic                rsp_cout;

    int total = 0;
    int bad   = 0;

    adder_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_chain (req_chain),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; checks follow 1 time unit later.
    task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic chain);
        req_a[id*16 +: 16] = a;
        req_b[id*16 +: 16] = b;
        req_cin[id]        = cin;
        req_chain[id]      = chain;
    endtask

    task automatic single(input int id, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic [15:0] es, input logic ec);
        @(negedge Clk);
        set_req(id, a, b, cin, 1'b0);
        req_valid = NREQ'(1 << id);
        #1 chk("single_ready", req_ready, 1 << id);
        @(negedge Clk);
        req_valid = '0;
        #1;
        chk("single_valid", rsp_valid, 1);
        chk("single_id", rsp_id, id);
        chk("single_sum", rsp_sum, es);
        chk("single_cout", rsp_cout, ec);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        req_valid = '0;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Protocol monitors: one-hot grant and a frozen response under backpressure.
    always @(negedge Clk) begin
        #2 chk("onehot0", $onehot0(req_ready), 1);
    end

    logic        hold_q = 1'b0;
    logic [19:0] held_q;
    always @(posedge Clk) begin
        if (hold_q) chk("rsp_stable", {rsp_cout, rsp_id, rsp_valid, rsp_sum}, held_q);
        hold_q = rsp_valid && !rsp_ready && !Reset;
        held_q = {rsp_cout, rsp_id, rsp_valid, rsp_sum};
    end

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0};
        vecs[1] = '{1, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1};
        vecs[2] = '{2, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[3] = '{3, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[4] = '{0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
        vecs[5] = '{1, 16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0};
        vecs[6] = '{2, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
        vecs[7] = '{3, 16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};
        vecs[8] = '{0, 16'h00FF, 16'h00FF, 1'b1, 16'h01FF, 1'b0};
        vecs[9] = '{1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};

        Reset     = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        req_chain = '0;
        rsp_ready = 1'b1;

        // Reset state, with every requester asking during reset.
        @(negedge Clk);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_sum", rsp_sum, 0);
        chk("rst_cout", rsp_cout, 0);
        Reset = 1'b0;
        req_valid = '0;

        // Single op then idle drain.
        single(0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
        @(negedge Clk);
        #1 chk("drain_valid", rsp_valid, 0);

        for (int i = 0; i < 10; i++)
            single(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);

        // Round robin with all requesters valid every cycle.
        do_reset();
        for (int r = 0; r < NREQ; r++) set_req(r, 16'h0001, 16'h0001, 1'b0, 1'b0);
        req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge Clk);
            #1;
            if (k < 5) chk("rr_ready", req_ready, 1 << (k % 4));
            if (k > 0) begin
                chk("rr_valid", rsp_valid, 1);
                chk("rr_id", rsp_id, (k - 1) % 4);
                chk("rr_sum", rsp_sum, 16'h0002);
            end
        end
        req_valid = '0;

        // Chain on req2 with req1 competing; pointer steered to 2 first.
        do_reset();
        single(1, 16'h0005, 16'h0005, 1'b0, 16'h000A, 1'b0);
        @(negedge Clk);
        set_req(2, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        set_req(1, 16'h0005, 16'h0005, 1'b0, 1'b0);
        req_valid = 4'b0110;
        #1 chk("ch0_ready", req_ready, 4'b0100);
        @(negedge Clk);
        req_valid = 4'b0010;
        #1;
        chk("ch0_id", rsp_id, 2);
        chk("ch0_sum", rsp_sum, 16'h0000);
        chk("ch0_cout", rsp_cout, 1);
        chk("ch_lock_ready", req_ready, 0);
        @(negedge Clk);
        set_req(2, 16'h0000, 16'h0000, 1'b0, 1'b0);
        req_valid = 4'b0110;
        #1;
        chk("ch_gap_valid", rsp_valid, 0);
        chk("ch1_ready", req_ready, 4'b0100);
        @(negedge Clk);
        req_valid = 4'b0010;
        #1;
        chk("ch1_id", rsp_id, 2);
        chk("ch1_sum", rsp_sum, 16'h0001);
        chk("ch1_cout", rsp_cout, 0);
        chk("ch_rel_ready", req_ready, 4'b0010);
        @(negedge Clk);
        req_valid = '0;
        #1;
        chk("ch_after_id", rsp_id, 1);
        chk("ch_after_sum", rsp_sum, 16'h000A);

        // Backpressure: three stalled cycles, then drain and fill together.
        @(negedge Clk);
        rsp_ready = 1'b0;
        set_req(0, 16'h0001, 16'h0002, 1'b0, 1'b0);
        req_valid = 4'b0001;
        #1 chk("bp_first_ready", req_ready, 4'b0001);
        @(negedge Clk);
        set_req(0, 16'h0010, 16'h0020, 1'b0, 1'b0);
        #1;
        chk("bp_valid", rsp_valid, 1);
        chk("bp_sum", rsp_sum, 16'h0003);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge Clk);
            #1;
            chk("bp_stall_ready", req_ready, 0);
            chk("bp_stall_sum", rsp_sum, 16'h0003);
        end
        @(negedge Clk);
        rsp_ready = 1'b1;
        #1 chk("bp_release_ready", req_ready, 4'b0001);
        @(negedge Clk);
        req_valid = '0;
        #1;
        chk("bp_new_valid", rsp_valid, 1);
        chk("bp_new_sum", rsp_sum, 16'h0030);
        @(negedge Clk);
        #1 chk("bp_drain_valid", rsp_valid, 0);

        // Reset while locked on req3; pointer must restart at 0.
        @(negedge Clk);
        set_req(3, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        req_valid = 4'b1000;
        #1 chk("lk_ready", req_ready, 4'b1000);
        @(negedge Clk);
        Reset = 1'b1;
        set_req(3, 16'h0001, 16'h0001, 1'b0, 1'b0);
        set_req(0, 16'h0007, 16'h0008, 1'b0, 1'b0);
        req_valid = 4'b1001;
        #1;
        chk("lk_id", rsp_id, 3);
        chk("lk_sum", rsp_sum, 16'hFFFE);
        chk("lk_rst_ready", req_ready, 0);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("lk_rst_valid", rsp_valid, 0);
        chk("lk_rst_sum", rsp_sum, 0);
        chk("lk_post_ready", req_ready, 4'b0001);
        @(negedge Clk);
        req_valid = '0;
        #1;
        chk("lk_post_id", rsp_id, 0);
        chk("lk_post_sum", rsp_sum, 16'h000F);
        @(negedge Clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
